m68k_bus_arbiter: RTL
=====================

// Module: m68k_bus_arbiter
// PURPOSE
// - Owns 68000 bus mastership between the Pi-driven bus-cycle FSM and external DMA masters (BR/BG/BGACK).
// - Queues one Pi op request and releases it as op_grant only while the bus is ours.
// - Drives M68K_BG_n per 68000 arbitration rules; sits between the Pi register decode and the bus-cycle sequencer.
// PARAMETERS
// - SYNC_STAGES    3   flops on M68K_CLK/BR_n/BGACK_n inputs (>=2)
// - GRANT_TIMEOUT  8   c7m falling edges in GRANT with BR negated and no BGACK before BG is withdrawn (1..255)
// PORTS
// - c200m          in   1   system clock (PI_CLK domain)
// - rst_n          in   1   async active-low reset
// - M68K_CLK       in   1   raw 7 MHz 68k clock, synchronised internally
// - M68K_BR_n      in   1   raw bus request, synchronised internally
// - M68K_BGACK_n   in   1   raw bus grant acknowledge, synchronised internally
// - op_req         in   1   1-cycle pulse: Pi wrote ADDR_HI, bus cycle wanted
// - op_done        in   1   1-cycle pulse: bus-cycle FSM finished S7->S0
// - M68K_BG_n      out  1   bus grant to external master
// - op_grant       out  1   1-cycle pulse: bus-cycle FSM may start (waits c7m falling itself)
// - ext_owner      out  1   1 while external master holds or is granted the bus
// - op_overrun     out  1   sticky: op_req arrived while one already pending
// - ext_tenures    out  16  ARB_STATS_EN only: completed external tenures
// BEHAVIOUR
// - Reset (async, all outputs): M68K_BG_n=1, op_grant=0, ext_owner=0, op_overrun=0, ext_tenures=0; state=IDLE, pending=0, timeout count=0.
// - c7m_rise/c7m_fall: edge detect on the last two synchroniser stages; br, bgack: active-high synced versions.
// - pending set by op_req in any state; cleared on op_grant; op_req while pending=1 -> op_overrun<=1 (request kept, not duplicated).
// - op_req and op_grant same cycle with pending=0: IDLE grants next cycle (1-cycle min latency op_req->op_grant).
// - States:
//   IDLE    bus ours, idle. If br && c7m_fall -> GRANT (BG_n<=0). Else if pending && !br -> op_grant pulse, -> BUSY.
//           br wins over pending on same cycle; pending waits until back in IDLE.
//   BUSY    own cycle in flight; br ignored. op_done -> IDLE (grant check restarts next cycle).
//   GRANT   BG_n=0, ext_owner=1. bgack -> EXT, BG_n<=1 same edge.
//           !br && !bgack: count c7m_fall; count==GRANT_TIMEOUT -> IDLE, BG_n<=1, count<=0.
//           br re-asserted -> count<=0.
//   EXT     BG_n=1, ext_owner=1; op_grant never issued. !bgack -> RECOVER.
//   RECOVER ext_owner=1; next c7m_rise -> IDLE, ext_owner<=0. br during RECOVER honoured only from IDLE.
// - op_done outside BUSY ignored. BG_n only changes on entry/exit of GRANT, never in IDLE/BUSY/EXT/RECOVER.
// - Reset mid-GRANT/EXT: BG_n released immediately (async); external BGACK after reset is ignored until state returns through IDLE->GRANT.
// - Counter widths: timeout 8 bit, saturating; ext_tenures 16 bit, wraps 0xFFFF->0.
// CONFIGURATION
// - ARB_STATS_EN defined: ext_tenures increments by 1 on each EXT->RECOVER transition.
// - ARB_STATS_EN undefined: port ext_tenures present, tied 16'h0000, no counter flops.
// TESTING
// - Reset then op_req pulse, no BR -> op_grant 1 cycle after op_req; BG_n stays 1; op_done returns IDLE.
// - BR low in IDLE -> BG_n=0 on first c7m falling edge after SYNC_STAGES sync; BGACK low -> BG_n=1 same cycle as EXT entry.
// - BR low during BUSY -> BG_n stays 1 until op_done, then 0 at next c7m fall.
// - op_req during EXT -> no op_grant until BGACK high + c7m rise; then op_grant once; second op_req while pending -> op_overrun=1.
// - BR pulse then released, no BGACK -> BG_n=1 after exactly 8 c7m falls (GRANT_TIMEOUT=8), state IDLE.
// - rst_n low while in EXT -> BG_n=1, ext_owner=0 immediately; ARB_STATS_EN: 3 full tenures -> ext_tenures=3.

Source files
------------

// File: rtl/m68k_bus_arbiter.sv
// 68000 bus mastership arbiter: Pi bus-cycle FSM vs external DMA (BR/BG/BGACK).
// Define ARB_STATS_EN to count completed external tenures on ext_tenures.
module m68k_bus_arbiter #(
   parameter int SYNC_STAGES   = 3,
   parameter int GRANT_TIMEOUT = 8
) (
   input  logic        c200m,
   input  logic        rst_n,
   input  logic        M68K_CLK,
   input  logic        M68K_BR_n,
   input  logic        M68K_BGACK_n,
   input  logic        op_req,
   input  logic        op_done,
   output logic        M68K_BG_n,
   output logic        op_grant,
   output logic        ext_owner,
   output logic        op_overrun,
   output logic [15:0] ext_tenures
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_BUSY,
      S_GRANT,
      S_EXT,
      S_RECOVER
   } state_t;

   state_t r_state;
   state_t w_state_nx;

   logic [SYNC_STAGES-1:0] r_clk_s;
   logic [SYNC_STAGES-1:0] r_br_s;
   logic [SYNC_STAGES-1:0] r_bgack_s;

   logic       w_c7m_rise;
   logic       w_c7m_fall;
   logic       w_br;
   logic       w_bgack;
   logic       w_grant;
   logic       r_pending;
   logic       r_overrun;
   logic       r_bg_n;
   logic [7:0] r_tcnt;
   logic [7:0] w_tcnt_nx;
   logic [7:0] w_tcnt_inc;

   // Strobes and bus requests idle negated out of reset.
   always_ff @(posedge c200m or negedge rst_n) begin
      if (!rst_n) begin
         r_clk_s   <= '0;
         r_br_s    <= '1;
         r_bgack_s <= '1;
      end else begin
         r_clk_s   <= {r_clk_s[SYNC_STAGES-2:0], M68K_CLK};
         r_br_s    <= {r_br_s[SYNC_STAGES-2:0], M68K_BR_n};
         r_bgack_s <= {r_bgack_s[SYNC_STAGES-2:0], M68K_BGACK_n};
      end
   end

   assign w_c7m_fall = r_clk_s[SYNC_STAGES-1] & ~r_clk_s[SYNC_STAGES-2];
   assign w_c7m_rise = ~r_clk_s[SYNC_STAGES-1] & r_clk_s[SYNC_STAGES-2];
   assign w_br       = ~r_br_s[SYNC_STAGES-1];
   assign w_bgack    = ~r_bgack_s[SYNC_STAGES-1];
   assign w_tcnt_inc = (r_tcnt == 8'hFF) ? r_tcnt : r_tcnt + 8'd1;

   always_comb begin
      w_state_nx = r_state;
      w_tcnt_nx  = r_tcnt;
      w_grant    = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_br && w_c7m_fall) begin
               w_state_nx = S_GRANT;
            end else if (r_pending && !w_br) begin
               w_grant    = 1'b1;
               w_state_nx = S_BUSY;
            end
         end
         S_BUSY: begin
            if (op_done) w_state_nx = S_IDLE;
         end
         S_GRANT: begin
            if (w_bgack) begin
               w_state_nx = S_EXT;
               w_tcnt_nx  = 8'd0;
            end else if (w_br) begin
               w_tcnt_nx = 8'd0;
            end else if (w_c7m_fall) begin
               // Requester vanished without acknowledging: withdraw BG.
               if (w_tcnt_inc == 8'(GRANT_TIMEOUT)) begin
                  w_state_nx = S_IDLE;
                  w_tcnt_nx  = 8'd0;
               end else begin
                  w_tcnt_nx = w_tcnt_inc;
               end
            end
         end
         S_EXT: begin
            if (!w_bgack) w_state_nx = S_RECOVER;
         end
         S_RECOVER: begin
            if (w_c7m_rise) w_state_nx = S_IDLE;
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge c200m or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_tcnt    <= 8'd0;
         r_bg_n    <= 1'b1;
         r_pending <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_tcnt    <= w_tcnt_nx;
         r_bg_n    <= (w_state_nx != S_GRANT);
         r_pending <= op_req | (r_pending & ~w_grant);
         if (op_req && r_pending && !w_grant) r_overrun <= 1'b1;
      end
   end

   assign M68K_BG_n  = r_bg_n;
   assign op_grant   = w_grant;
   assign op_overrun = r_overrun;
   assign ext_owner  = (r_state == S_GRANT) ||
                       (r_state == S_EXT) ||
                       (r_state == S_RECOVER);

`ifdef ARB_STATS_EN
   logic [15:0] r_tenures;

   always_ff @(posedge c200m or negedge rst_n) begin
      if (!rst_n) begin
         r_tenures <= 16'h0000;
      end else if (r_state == S_EXT && !w_bgack) begin
         r_tenures <= r_tenures + 16'd1;
      end
   end

   assign ext_tenures = r_tenures;
`else
   assign ext_tenures = 16'h0000;
`endif

endmodule
